// File: rtl/seq_shifter_lr.sv
// ---------------------------------------------------------------------------
// seq_shifter_lr
//
// Multi-cycle bidirectional logical shifter with valid/ready handshakes.
// A request is accepted in IDLE. The word then moves one bit position per
// clock in SHIFT. The result is presented in DONE until the consumer takes it.
// The result is the same as a combinational left/right barrel shifter, but it
// takes shift_amt cycles instead of a wide mux tree.
//
// Optional build feature (macro SEQ_SHIFTER_ROTATE_EN):
//   Adds input `rot`. rot is latched at accept. When rot=1, every step is a
//   rotate instead of a zero-filling shift. Latency and handshake are unchanged.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  block idle and able to accept (forced low in reset)
//   din        in   operand, WIDTH bits
//   dir        in   0 = shift left, 1 = shift right
//   shift_amt  in   number of positions, AMT_W bits
//   out_valid  out  result valid (state DONE)
//   out_ready  in   consumer accepts result
//   dout       out  result register (intermediate values visible while busy)
//   busy       out  state is not IDLE
//   rot        in   (SEQ_SHIFTER_ROTATE_EN only) rotate instead of shift
// ---------------------------------------------------------------------------
module seq_shifter_lr #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic [AMT_W-1:0] shift_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
`ifdef SEQ_SHIFTER_ROTATE_EN
    ,
    input  logic             rot
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic               dir_q, dir_d;
    logic               rot_q, rot_d;
    logic               out_valid_q;
    logic               busy_q;
    logic               idle_q;
    logic               rot_in_s;

`ifdef SEQ_SHIFTER_ROTATE_EN
    assign rot_in_s = rot;
`else
    // Without the rotate feature every step zero-fills.
    assign rot_in_s = 1'b0;
`endif

    // One-position step. In rotate mode, the bit leaving one end re-enters the other end.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] data,
        input logic             right,
        input logic             rotate
    );
        logic fill_s;
        if (right) begin
            fill_s = rotate ? data[0] : 1'b0;
            return {fill_s, data[WIDTH-1:1]};
        end else begin
            fill_s = rotate ? data[WIDTH-1] : 1'b0;
            return {data[WIDTH-2:0], fill_s};
        end
    endfunction

    // Next-state, datapath and counter update.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        count_d = count_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        case (state_q)
            ST_IDLE: begin
                // in_ready is 1 in IDLE whenever edges take effect, so in_valid alone means accept.
                if (in_valid) begin
                    dout_d  = din;
                    count_d = shift_amt;
                    dir_d   = dir;
                    rot_d   = rot_in_s;
                    if (shift_amt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                dout_d  = shift_step(dout_q, dir_q, rot_q);
                count_d = count_q - AMT_ONE;
                // The last step completes on the edge where the count is 1.
                if (count_q == AMT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags.
    // The flags are decoded from state_d so that they change together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dout_q      <= '0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            rot_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            rot_q       <= rot_d;
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
            idle_q      <= (state_d == ST_IDLE);
        end
    end

    // in_ready must drop as soon as reset asserts, so it is gated by rst_n.
    assign in_ready  = idle_q & rst_n;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_seq_shifter_lr.sv
// ---------------------------------------------------------------------------
// Self-checking bench for seq_shifter_lr.
//
// A transaction-level model tracks these values:
//   - whether a request is in flight,
//   - the number of edges since it was accepted,
//   - the last delivered result.
// From them it computes the expected outputs on every falling edge.
// Directed requests add literal checks on results, latency and handshake.
// ---------------------------------------------------------------------------
module tb_seq_shifter_lr;
    localparam int W  = 4;
    localparam int AW = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          dir       = 1'b0;
    logic          out_ready = 1'b0;
    logic          rot_s     = 1'b0;
    logic [W-1:0]  din       = '0;
    logic [AW-1:0] shift_amt = '0;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  dout;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    seq_shifter_lr #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .dir       (dir),
        .shift_amt (shift_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
`ifdef SEQ_SHIFTER_ROTATE_EN
        ,
        .rot       (rot_s)
`endif
    );

    // Shift or rotate d by k places, computed in one step with arithmetic.
    function automatic logic [W-1:0] shf(input logic [W-1:0] d, input logic dr,
                                         input logic rt, input int k);
        int km;
        if (!rt) begin
            if (dr) return d >> k;
            else    return d << k;
        end
        km = k % W;
        if (km == 0) return d;
        if (dr) return (d >> km) | (d << (W - km));
        else    return (d << km) | (d >> (W - km));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    logic         m_busy = 1'b0;
    int           m_k    = 0;
    int           m_n    = 0;
    logic [W-1:0] m_din  = '0;
    logic         m_dir  = 1'b0;
    logic         m_rot  = 1'b0;
    logic [W-1:0] m_last = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_last <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_n    <= int'(shift_amt);
                m_din  <= din;
                m_dir  <= dir;
                m_rot  <= rot_s;
            end
        end else if (m_k >= m_n) begin
            if (out_ready) begin
                m_busy <= 1'b0;
                m_last <= shf(m_din, m_dir, m_rot, m_n);
            end
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_in_ready",  32'(in_ready),  32'(rst_n && !m_busy));
            check("cyc_busy",      32'(busy),      32'(m_busy));
            check("cyc_out_valid", 32'(out_valid), 32'(m_busy && (m_k >= m_n)));
            check("cyc_dout",      32'(dout),
                  32'(m_busy ? shf(m_din, m_dir, m_rot, m_k) : m_last));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check("wait_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_req(input string name, input logic [W-1:0] d, input logic dr,
                           input logic rt, input logic [AW-1:0] amt,
                           input logic [W-1:0] exp_dout, input int exp_lat);
        int lat;
        wait_ready();
        din = d; dir = dr; rot_s = rt; shift_amt = amt; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Scramble the operand inputs. The block must ignore them while busy.
        din = ~d; dir = ~dr; shift_amt = ~amt;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_dout"}, 32'(dout), 32'(exp_dout));
        check({name, "_busy"}, 32'(busy), 32'd1);
        out_ready = 1'b1;
        tick();
        check({name, "_handoff_valid"}, 32'(out_valid), 32'd0);
        check({name, "_handoff_busy"}, 32'(busy), 32'd0);
        check({name, "_handoff_ready"}, 32'(in_ready), 32'd1);
        check({name, "_hold_dout"}, 32'(dout), 32'(exp_dout));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Pin the model against hand-computed values.
        check("model_l3",   32'(shf(4'b0101, 1'b0, 1'b0, 3)), 32'h8);
        check("model_r2",   32'(shf(4'b1101, 1'b1, 1'b0, 2)), 32'h3);
        check("model_rr2",  32'(shf(4'b1101, 1'b1, 1'b1, 2)), 32'h7);
        check("model_rl1",  32'(shf(4'b1001, 1'b0, 1'b1, 1)), 32'h3);

        // Outputs while reset is held.
        #2;
        check("rst_dout",      32'(dout),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        run_req("l0", 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001, 0);
        out_ready = 1'b0;
        run_req("l3", 4'b0101, 1'b0, 1'b0, 2'd3, 4'b1000, 3);

        // Back-to-back requests with out_ready held high.
        out_ready = 1'b1;
        run_req("r2", 4'b0111, 1'b1, 1'b0, 2'd2, 4'b0001, 2);
        run_req("r1", 4'b1001, 1'b1, 1'b0, 2'd1, 4'b0100, 1);
        run_req("r3", 4'b1111, 1'b1, 1'b0, 2'd3, 4'b0001, 3);
        run_req("l3b", 4'b1111, 1'b0, 1'b0, 2'd3, 4'b1000, 3);

        // Backpressure: hold the result, and ignore a competing request.
        out_ready = 1'b0;
        wait_ready();
        din = 4'b1101; dir = 1'b1; shift_amt = 2'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        in_valid = 1'b1; din = 4'b1111; dir = 1'b0; shift_amt = 2'd0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_dout",  32'(dout),      32'h3);
            check("bp_ready", 32'(in_ready),  32'd0);
            tick();
        end
        check("bp_dout_end", 32'(dout), 32'h3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_busy",  32'(busy),      32'd0);
        check("bp_release_dout",  32'(dout),      32'h3);

        // Asynchronous reset in the middle of a shift.
        wait_ready();
        din = 4'b0101; dir = 1'b0; shift_amt = 2'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_dout", 32'(dout), 32'ha);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_dout",      32'(dout),      32'd0);
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_busy",      32'(busy),      32'd0);
        check("async_in_ready",  32'(in_ready),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        run_req("post_rst", 4'b0010, 1'b1, 1'b0, 2'd1, 4'b0001, 1);

`ifdef SEQ_SHIFTER_ROTATE_EN
        run_req("rot_r2", 4'b1101, 1'b1, 1'b1, 2'd2, 4'b0111, 2);
        run_req("rot_l1", 4'b1001, 1'b0, 1'b1, 2'd1, 4'b0011, 1);
        run_req("rot_l3", 4'b1001, 1'b0, 1'b1, 2'd3, 4'b1100, 3);
        run_req("rot_off", 4'b1101, 1'b1, 1'b0, 2'd2, 4'b0011, 2);
`endif

        tick();
        tick();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
